// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, used by the sync generator and the renderer.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    // Half-open window test [lo, hi) on unsigned coordinates.
    function automatic logic in_window(input logic [COORD_W-1:0] v,
                                       input logic [COORD_W-1:0] lo,
                                       input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/edge_tick.sv
// Rising-edge detector: one-cycle tick when a level synchronous to clk goes 0 -> 1.
module edge_tick (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic tick
);
    import vga_timing_pkg::*;

    logic level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    // Cleared history makes a level that is already high after reset count as an edge.
    assign tick = level & ~level_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA h/v timing generator advanced by pixel_rate edges; all outputs registered together.
module vga_sync_gen #(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic                               CLK_NX,
    input  logic                               reset,
    input  logic                               pixel_rate,
    input  logic                               clk_RING,
    output logic                               pixel_tick,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               video_on,
    output logic [vga_timing_pkg::COORD_W-1:0] pixel_x,
    output logic [vga_timing_pkg::COORD_W-1:0] pixel_y,
    output logic                               frame_start,
    output logic                               blink
);
    import vga_timing_pkg::*;

    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOT > (1 << COORD_W) || V_TOT > (1 << COORD_W)) begin : g_bad_timing
        $error("vga_sync_gen: line or frame total does not fit the coordinate width");
    end

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] X_VIS  = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] Y_VIS  = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_LO  = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_HI  = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_LO  = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_HI  = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic               tick;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;
    logic               wrap_frame;

    edge_tick u_pixel_edge (
        .clk   (CLK_NX),
        .reset (reset),
        .level (pixel_rate),
        .tick  (tick)
    );

    always_comb begin
        x_nxt      = pixel_x;
        y_nxt      = pixel_y;
        wrap_frame = 1'b0;
        if (tick) begin
            if (pixel_x == X_LAST) begin
                x_nxt = '0;
                if (pixel_y == Y_LAST) begin
                    y_nxt      = '0;
                    wrap_frame = 1'b1;
                end else begin
                    y_nxt = pixel_y + COORD_W'(1);
                end
            end else begin
                x_nxt = pixel_x + COORD_W'(1);
            end
        end
    end

    // Decode from the next-state counters so sync/video land on the same edge as x/y.
    always_ff @(posedge CLK_NX) begin
        if (reset) begin
            pixel_x     <= X_LAST;
            pixel_y     <= Y_LAST;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
            blink       <= 1'b0;
        end else begin
            pixel_x     <= x_nxt;
            pixel_y     <= y_nxt;
            hsync       <= ~in_window(x_nxt, HS_LO, HS_HI);
            vsync       <= ~in_window(y_nxt, VS_LO, VS_HI);
            video_on    <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
            pixel_tick  <= tick;
            frame_start <= wrap_frame;
            blink       <= clk_RING;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance plus a shrunk-timing instance so whole frames fit.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, pixel_rate, clk_ring;

    logic       d_tick, d_hs, d_vs, d_vo, d_fs, d_bl;
    logic [9:0] d_x, d_y;
    logic       s_tick, s_hs, s_vs, s_vo, s_fs, s_bl;
    logic [9:0] s_x, s_y;

    vga_sync_gen dut (
        .CLK_NX(clk), .reset(reset), .pixel_rate(pixel_rate), .clk_RING(clk_ring),
        .pixel_tick(d_tick), .hsync(d_hs), .vsync(d_vs), .video_on(d_vo),
        .pixel_x(d_x), .pixel_y(d_y), .frame_start(d_fs), .blink(d_bl)
    );

    // 15 x 10 frame: 150 ticks per frame
    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_s (
        .CLK_NX(clk), .reset(reset), .pixel_rate(pixel_rate), .clk_RING(clk_ring),
        .pixel_tick(s_tick), .hsync(s_hs), .vsync(s_vs), .video_on(s_vo),
        .pixel_x(s_x), .pixel_y(s_y), .frame_start(s_fs), .blink(s_bl)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    // Model: number of ticks since reset; position is that count along a raster of the frame.
    int m_n;
    bit m_prev, m_tick, m_blink;

    always @(posedge clk) begin
        if (reset) begin
            m_n = 0; m_prev = 0; m_tick = 0; m_blink = 0;
        end else begin
            m_tick  = pixel_rate && !m_prev;
            m_prev  = pixel_rate;
            m_blink = clk_ring;
            if (m_tick) m_n++;
        end
    end

    task automatic cmp_inst(input string nm,
                            input int hv, input int hf, input int hs, input int hb,
                            input int vv, input int vf, input int vs, input int vb,
                            input logic [9:0] ax, input logic [9:0] ay,
                            input logic atk, input logic ahs, input logic avs,
                            input logic avo, input logic afs, input logic abl);
        int ht, vt, tot, lin, ex, ey;
        logic ehs, evs, evo, efs;
        logic [25:0] act, expv;
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        tot = ht * vt;
        lin = (m_n == 0) ? tot - 1 : (m_n - 1) % tot;
        ex  = lin % ht;
        ey  = lin / ht;
        ehs = !(ex >= hv + hf && ex < hv + hf + hs);
        evs = !(ey >= vv + vf && ey < vv + vf + vs);
        evo = (ex < hv) && (ey < vv);
        efs = m_tick && (m_n > 0) && ((m_n - 1) % tot == 0);
        expv = {10'(ex), 10'(ey), m_tick, ehs, evs, evo, efs, m_blink};
        act  = {ax, ay, atk, ahs, avs, avo, afs, abl};
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s per-cycle {x,y,tick,hs,vs,vo,fs,blink}: got %h want %h at %0t",
                      nm, act, expv, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst("dut", 640, 16, 96, 48, 480, 10, 2, 33,
                     d_x, d_y, d_tick, d_hs, d_vs, d_vo, d_fs, d_bl);
            cmp_inst("dut_s", 8, 2, 3, 2, 6, 1, 2, 1,
                     s_x, s_y, s_tick, s_hs, s_vs, s_vo, s_fs, s_bl);
        end
    end

    task automatic lit(input string nm, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, expv);
    endtask

    bit run_pr;
    int pr_cnt;

    // One clock; inputs change 3 ns after the edge, outputs are read then too.
    task automatic cyc();
        @(posedge clk);
        #3;
        if (run_pr) begin
            pr_cnt++;
            if (pr_cnt == 2) begin
                pr_cnt = 0;
                pixel_rate = ~pixel_rate;
            end
        end
    endtask

    int   found, hs_low, vo_fall_x, hs_fall_x, hs_rise_x, ticks, changed;
    int   t0, t1, vs_ticks;
    logic prev_vo, prev_hs, prev_ring;
    logic [9:0] sx, sy;
    logic shs, svs, svo;

    initial begin
        reset = 1'b1; pixel_rate = 1'b0; clk_ring = 1'b1;
        run_pr = 0; pr_cnt = 0;
        cyc();
        chk_en = 1;
        cyc(); cyc();
        lit("rst_x", d_x, 799);
        lit("rst_y", d_y, 524);
        lit("rst_hsync", d_hs, 1);
        lit("rst_vsync", d_vs, 1);
        lit("rst_video_on", d_vo, 0);
        lit("rst_blink", d_bl, 0);
        lit("rst_tick", d_tick, 0);
        lit("rst_frame_start", d_fs, 0);
        lit("rst_small_x", s_x, 14);

        reset = 1'b0;
        run_pr = 1;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            cyc();
            if (d_tick) found = 1;
        end
        lit("first_tick_seen", found, 1);
        lit("first_frame_start", d_fs, 1);
        lit("first_x", d_x, 0);
        lit("first_y", d_y, 0);
        lit("first_video_on", d_vo, 1);
        lit("first_hsync", d_hs, 1);
        lit("first_blink", d_bl, 1);

        hs_low = 0; vo_fall_x = -1; hs_fall_x = -1; hs_rise_x = -1;
        prev_vo = d_vo; prev_hs = d_hs;
        for (int i = 0; i < 3200; i++) begin
            cyc();
            if (!d_hs) hs_low++;
            if (prev_vo && !d_vo && vo_fall_x < 0) vo_fall_x = d_x;
            if (prev_hs && !d_hs && hs_fall_x < 0) hs_fall_x = d_x;
            if (!prev_hs && d_hs && hs_rise_x < 0) hs_rise_x = d_x;
            prev_vo = d_vo; prev_hs = d_hs;
        end
        lit("hsync_low_cycles", hs_low, 384);
        lit("hsync_fall_x", hs_fall_x, 656);
        lit("hsync_rise_x", hs_rise_x, 752);
        lit("video_off_x", vo_fall_x, 640);
        lit("line_end_x", d_x, 0);
        lit("line_end_y", d_y, 1);

        run_pr = 0;
        pixel_rate = 1'b1;
        cyc(); cyc();
        sx = d_x; sy = d_y; shs = d_hs; svs = d_vs; svo = d_vo;
        ticks = 0; changed = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            if (d_tick) ticks++;
            if (d_x != sx || d_y != sy || d_hs != shs || d_vs != svs || d_vo != svo) changed++;
        end
        lit("hold_ticks", ticks, 0);
        lit("hold_changed", changed, 0);

        run_pr = 1; pr_cnt = 0;
        t0 = -1; t1 = -1; vs_ticks = 0;
        for (int i = 0; i < 2000 && t1 < 0; i++) begin
            cyc();
            if (s_fs) begin
                if (t0 < 0) t0 = i;
                else t1 = i;
            end
            if (t0 >= 0 && t1 < 0 && s_tick && !s_vs) vs_ticks++;
        end
        lit("small_frame_gap_cycles", t1 - t0, 600);
        lit("small_vsync_low_ticks", vs_ticks, 30);

        run_pr = 0;
        pixel_rate = 1'b1;
        reset = 1'b1;
        cyc();
        lit("midrst_x", d_x, 799);
        lit("midrst_y", d_y, 524);
        lit("midrst_video_on", d_vo, 0);
        lit("midrst_hsync", d_hs, 1);
        lit("midrst_frame_start", d_fs, 0);
        reset = 1'b0;
        cyc();
        lit("postrst_tick", d_tick, 1);
        lit("postrst_frame_start", d_fs, 1);
        lit("postrst_x", d_x, 0);
        lit("postrst_y", d_y, 0);
        lit("postrst_video_on", d_vo, 1);
        cyc();
        lit("postrst_no_second_tick", d_tick, 0);
        lit("postrst_fs_one_cycle", d_fs, 0);

        for (int i = 0; i < 6; i++) begin
            prev_ring = clk_ring;
            clk_ring = ~clk_ring;
            lit("blink_before_edge", d_bl, prev_ring);
            cyc();
            lit("blink_after_edge", d_bl, clk_ring);
        end

        cyc();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
